// File: rtl/xor_stream_cipher.sv
// xor_stream_cipher: registered XOR stream cipher with a valid/ready handshake.
// The keystream word comes from one of four sources: zero (bypass), a fixed
// key word, a rotating key word from a serially loaded key bank, or a Galois LFSR.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   ena                 clock enable; no state changes while low
//   mode[1:0]           00 bypass, 01 fixed key, 10 rotating key, 11 LFSR
//   key_ld, key_sdi     serial key load strobe and data bit (MSB of bank first)
//   in_valid/in_data    input word; in_ready is combinational
//   out_valid/out_data  registered output word; out_ready from the sink
//   key_busy            combinational copy of key_ld
module xor_stream_cipher #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned KEY_DEPTH = 4,
  parameter logic [15:0] KEY_INIT  = 16'h00BE,
  parameter logic [15:0] POLY      = 16'h00B8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [1:0]        mode,
  input  logic              key_ld,
  input  logic              key_sdi,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              key_busy
);

  localparam int unsigned BANK_W = DATA_W * KEY_DEPTH;
  localparam int unsigned IDX_W  = (KEY_DEPTH > 1) ? $clog2(KEY_DEPTH) : 1;

  localparam logic [DATA_W-1:0] KEY_INIT_W = DATA_W'(KEY_INIT);
  localparam logic [DATA_W-1:0] POLY_W     = DATA_W'(POLY);
  localparam logic [DATA_W-1:0] SEED_RST   = (KEY_INIT_W == '0) ? DATA_W'(1) : KEY_INIT_W;
  localparam logic [BANK_W-1:0] BANK_RST   = {KEY_DEPTH{KEY_INIT_W}};

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'b00,
    MODE_FIXED  = 2'b01,
    MODE_ROTATE = 2'b10,
    MODE_LFSR   = 2'b11
  } mode_e;

  logic [BANK_W-1:0] r_bank;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_lfsr;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_ld_d;

  logic [BANK_W-1:0] w_bank_nxt;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic [DATA_W-1:0] w_lfsr_nxt;
  logic              w_out_valid_nxt;
  logic [DATA_W-1:0] w_out_data_nxt;
  logic              w_ld_d_nxt;

  logic              w_accept;
  logic              w_xfer;
  logic              w_load_end;
  logic [DATA_W-1:0] w_seed;
  logic [IDX_W-1:0]  w_idx_cur;
  logic [DATA_W-1:0] w_lfsr_cur;
  logic [DATA_W-1:0] w_ks;
  mode_e             w_mode;
  logic [DATA_W-1:0] w_key [KEY_DEPTH];

  // Word view of the key bank; key[0] is the least significant word.
  for (genvar g = 0; g < KEY_DEPTH; g++) begin : g_key
    assign w_key[g] = r_bank[g*DATA_W +: DATA_W];
  end

  assign in_ready   = !key_ld && (!r_out_valid || out_ready);
  assign key_busy   = key_ld;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;

  assign w_mode     = mode_e'(mode);
  assign w_accept   = ena && in_valid && in_ready;
  assign w_xfer     = ena && r_out_valid && out_ready;
  assign w_load_end = ena && !key_ld && r_ld_d;

  // A zero key word would lock the LFSR, so it is seeded with 1 instead.
  assign w_seed     = (w_key[0] == '0) ? DATA_W'(1) : w_key[0];

  // On the load-end cycle the restarted idx/seed are already in effect, so an
  // accept on that same cycle uses them.
  assign w_idx_cur  = w_load_end ? '0 : r_idx;
  assign w_lfsr_cur = w_load_end ? w_seed : r_lfsr;

  // Next-state logic for datapath, key bank and keystream generators.
  always_comb begin
    w_bank_nxt      = r_bank;
    w_idx_nxt       = w_idx_cur;
    w_lfsr_nxt      = w_lfsr_cur;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_ld_d_nxt      = r_ld_d;
    w_ks            = '0;

    case (w_mode)
      MODE_BYPASS: w_ks = '0;
      MODE_FIXED:  w_ks = w_key[0];
      MODE_ROTATE: w_ks = w_key[w_idx_cur];
      MODE_LFSR:   w_ks = w_lfsr_cur;
      default:     w_ks = '0;
    endcase

    if (w_accept) begin
      w_out_data_nxt  = in_data ^ w_ks;
      w_out_valid_nxt = 1'b1;
      if (w_mode == MODE_ROTATE) begin
        w_idx_nxt = (w_idx_cur == IDX_W'(KEY_DEPTH - 1)) ? '0 : w_idx_cur + IDX_W'(1);
      end
      if (w_mode == MODE_LFSR) begin
        w_lfsr_nxt = (w_lfsr_cur >> 1) ^ (w_lfsr_cur[0] ? POLY_W : '0);
      end
    end else if (w_xfer) begin
      w_out_valid_nxt = 1'b0;
    end

    if (ena && key_ld) begin
      w_bank_nxt = {r_bank[BANK_W-2:0], key_sdi};
    end

    if (ena) begin
      w_ld_d_nxt = key_ld;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank      <= BANK_RST;
      r_idx       <= '0;
      r_lfsr      <= SEED_RST;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_ld_d      <= 1'b0;
    end else begin
      r_bank      <= w_bank_nxt;
      r_idx       <= w_idx_nxt;
      r_lfsr      <= w_lfsr_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_ld_d      <= w_ld_d_nxt;
    end
  end

endmodule

// File: tb/tb_xor_stream_cipher.sv
// Self-checking bench for xor_stream_cipher (DATA_W=8, KEY_DEPTH=4, defaults).
module tb_xor_stream_cipher;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [1:0] mode;
  logic       key_ld;
  logic       key_sdi;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       key_busy;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_bank;
  int          m_idx;
  logic [7:0]  m_lfsr;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_ld_prev;

  xor_stream_cipher #(
    .DATA_W    (8),
    .KEY_DEPTH (4),
    .KEY_INIT  (16'h00BE),
    .POLY      (16'h00B8)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .mode      (mode),
    .key_ld    (key_ld),
    .key_sdi   (key_sdi),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .key_busy  (key_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] key_word(input int i);
    return 8'(m_bank >> (8 * i));
  endfunction

  task automatic model_reset();
    m_bank    = {4{8'hBE}};
    m_idx     = 0;
    m_lfsr    = 8'hBE;
    m_valid   = 1'b0;
    m_data    = 8'h00;
    m_ld_prev = 1'b0;
  endtask

  // One clock: check combinational outputs, step the model, then check registers.
  task automatic tick();
    logic       exp_ready;
    logic       acc;
    logic       xfer;
    logic [7:0] k;
    logic [7:0] kw0;
    #1;
    exp_ready = !key_ld && (!m_valid || out_ready);
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    check("key_busy", 32'(key_busy), 32'(key_ld));
    if (ena) begin
      if (!key_ld && m_ld_prev) begin
        kw0    = key_word(0);
        m_idx  = 0;
        m_lfsr = (kw0 == 8'h00) ? 8'h01 : kw0;
      end
      acc  = in_valid && exp_ready;
      xfer = m_valid && out_ready;
      if (acc) begin
        case (mode)
          2'd0:    k = 8'h00;
          2'd1:    k = key_word(0);
          2'd2:    k = key_word(m_idx);
          default: k = m_lfsr;
        endcase
        m_data  = in_data ^ k;
        m_valid = 1'b1;
        if (mode == 2'd2) m_idx = (m_idx + 1) % 4;
        if (mode == 2'd3) m_lfsr = {1'b0, m_lfsr[7:1]} ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
      end else if (xfer) begin
        m_valid = 1'b0;
      end
      if (key_ld) m_bank = {m_bank[30:0], key_sdi};
      m_ld_prev = key_ld;
    end
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data", 32'(out_data), 32'(m_data));
  endtask

  // Shift the low nbits of v MSB first, then one idle cycle to end the load.
  task automatic load_key(input logic [31:0] v, input int nbits);
    ena = 1'b1;
    for (int i = nbits - 1; i >= 0; i--) begin
      key_ld  = 1'b1;
      key_sdi = v[i];
      tick();
    end
    key_ld   = 1'b0;
    key_sdi  = 1'b0;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] exp, input string tag);
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = 1'b1;
    tick();
    check(tag, 32'(out_data), 32'(exp));
  endtask

  logic [7:0] exp34 [5];

  initial begin
    exp34 = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h44};
    rst_n     = 1'b0;
    ena       = 1'b0;
    mode      = 2'd0;
    key_ld    = 1'b0;
    key_sdi   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    model_reset();

    #17;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // Fixed key after reset
    ena  = 1'b1;
    mode = 2'd1;
    send(8'h00, 8'hBE, "fixed_00");
    send(8'hFF, 8'h41, "fixed_ff");
    in_valid = 1'b0;
    tick();

    // Backpressure: one word held, next accepted together with the transfer
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h12;
    tick();
    check("bp_first", 32'(out_data), 32'hAC);
    in_data = 8'h34;
    check("bp_ready_low", 32'(in_ready), 32'd0);
    tick();
    check("bp_hold", 32'(out_data), 32'hAC);
    out_ready = 1'b1;
    tick();
    check("bp_second", 32'(out_data), 32'h8A);
    check("bp_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick();
    check("bp_drained", 32'(out_valid), 32'd0);

    // Rotating key with wrap; input offered during load must not be taken
    in_valid = 1'b1;
    in_data  = 8'h55;
    load_key(32'h11223344, 32);
    mode = 2'd2;
    for (int i = 0; i < 5; i++) send(8'h00, exp34[i], "rotate");
    in_valid = 1'b0;

    // LFSR seeded from key[0]
    load_key(32'h00000001, 32);
    mode = 2'd3;
    send(8'h00, 8'h01, "lfsr_0");
    send(8'h00, 8'hB8, "lfsr_1");
    send(8'h00, 8'h5C, "lfsr_2");
    send(8'h00, 8'h2E, "lfsr_3");
    in_valid = 1'b0;

    // Zero seed substitution, then bypass
    load_key(32'h00000000, 32);
    mode = 2'd3;
    send(8'h00, 8'h01, "lfsr_zero_seed");
    mode = 2'd0;
    send(8'h5A, 8'h5A, "bypass");
    in_valid = 1'b0;
    tick();

    // Randomized traffic with mode changes, enable gaps and partial key loads
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 39) == 0) begin
        in_valid = 1'($urandom_range(0, 1));
        load_key($urandom, int'($urandom_range(1, 32)));
      end
      ena       = ($urandom_range(0, 7) != 0);
      mode      = 2'($urandom_range(0, 3));
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end

    // Asynchronous reset while a word is held
    ena       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #3;
    rst_n = 1'b1;
    model_reset();
    mode     = 2'd1;
    in_valid = 1'b1;
    in_data  = 8'h00;
    tick();
    in_valid = 1'b0;
    check("held_be", 32'(out_data), 32'hBE);
    check("held_valid", 32'(out_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_data", 32'(out_data), 32'd0);
    #1;
    rst_n = 1'b1;
    model_reset();
    mode      = 2'd2;
    out_ready = 1'b1;
    send(8'h00, 8'hBE, "post_rst_rotate");
    in_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
